// File: rtl/la_pkg.sv
// Shared types and default widths for the logic-analyser capture controller.
package la_pkg;

    localparam int LA_ADDR_W = 8;
    localparam int LA_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } la_state_e;

endpackage

// File: rtl/la_edge_detect.sv
// Rising-edge detector: one history register, pulse is combinational from it.
module la_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_d_r;

    // Previous-cycle level used as the edge reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level;
        end
    end

    assign rise = level & ~level_d_r;

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: circular pre/post-trigger capture into an
// external sample buffer, followed by oldest-first readout.
module la_capture_ctrl #(
    parameter int ADDR_W = la_pkg::LA_ADDR_W,
    parameter int DATA_W = la_pkg::LA_DATA_W
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_btn,
    input  logic [DATA_W-1:0] i_trig_val,
    input  logic [DATA_W-1:0] i_trig_mask,
    input  logic [ADDR_W-1:0] i_post_len,
    input  logic              i_read,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_run,
    output logic              o_available,
    output logic [ADDR_W-1:0] o_trig_addr
);
    import la_pkg::*;

    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   FILL_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   FILL_FULL = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic trig_match(input logic [DATA_W-1:0] data,
                                        input logic [DATA_W-1:0] val,
                                        input logic [DATA_W-1:0] mask);
        return ((data ^ val) & mask) == {DATA_W{1'b0}};
    endfunction

    la_state_e         state_r, state_next_s;
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_next_s, rd_ptr_r, post_cnt_r, trig_addr_r;
    logic [ADDR_W:0]   fill_r, fill_next_s, remain_r;
    logic              wrapped_r, wrapped_next_s;
    logic              btn_rise_s, trig_hit_s, run_s, arm_s, done_enter_s;

    la_edge_detect u_btn_edge (
        .clk   (clk),
        .rst_n (_rst),
        .level (i_btn),
        .rise  (btn_rise_s)
    );

    assign run_s        = (state_r == ST_ARMED) || (state_r == ST_POST);
    assign trig_hit_s   = (state_r == ST_ARMED) && trig_match(i_data, i_trig_val, i_trig_mask);
    assign arm_s        = btn_rise_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign done_enter_s = (state_next_s == ST_DONE) && (state_r != ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a button edge in DONE discards the readout and re-arms.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (btn_rise_s) state_next_s = ST_ARMED;
                else            state_next_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (!trig_hit_s)                   state_next_s = ST_ARMED;
                else if (i_post_len == PTR_ZERO)   state_next_s = ST_DONE;
                else                               state_next_s = ST_POST;
            end
            ST_POST: begin
                if (post_cnt_r == PTR_ONE) state_next_s = ST_DONE;
                else                       state_next_s = ST_POST;
            end
            ST_DONE: begin
                if (btn_rise_s)                          state_next_s = ST_ARMED;
                else if (i_read && (remain_r == FILL_ONE)) state_next_s = ST_IDLE;
                else                                     state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        o_run       = 1'b0;
        o_available = 1'b0;
        o_wr_en     = 1'b0;
        o_wr_addr   = PTR_ZERO;
        o_wr_data   = {DATA_W{1'b0}};
        case (state_r)
            ST_ARMED, ST_POST: begin
                o_run     = 1'b1;
                o_wr_en   = 1'b1;
                o_wr_addr = wr_ptr_r;
                o_wr_data = i_data;
            end
            ST_DONE:  o_available = 1'b1;
            ST_IDLE:  o_available = 1'b0;
            default:  o_available = 1'b0;
        endcase
    end

    assign o_rd_addr   = rd_ptr_r;
    assign o_trig_addr = trig_addr_r;

    // Write pointer, wrap flag and saturating fill count for the coming edge.
    always_comb begin
        wr_ptr_next_s  = wr_ptr_r;
        wrapped_next_s = wrapped_r;
        fill_next_s    = fill_r;
        if (arm_s) begin
            wr_ptr_next_s  = PTR_ZERO;
            wrapped_next_s = 1'b0;
            fill_next_s    = FILL_ZERO;
        end else if (run_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            if (wr_ptr_r == PTR_MAX) wrapped_next_s = 1'b1;
            else                     wrapped_next_s = wrapped_r;
            if (fill_r != FILL_FULL) fill_next_s = fill_r + FILL_ONE;
            else                     fill_next_s = fill_r;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
    end

    // Capture and readout datapath registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wr_ptr_r    <= PTR_ZERO;
            wrapped_r   <= 1'b0;
            fill_r      <= FILL_ZERO;
            post_cnt_r  <= PTR_ZERO;
            trig_addr_r <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            remain_r    <= FILL_ZERO;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            wrapped_r <= wrapped_next_s;
            fill_r    <= fill_next_s;
            if (trig_hit_s) begin
                trig_addr_r <= wr_ptr_r;
                post_cnt_r  <= i_post_len;
            end else if (state_r == ST_POST) begin
                post_cnt_r  <= post_cnt_r - PTR_ONE;
            end
            // Readout starts at the oldest sample still held in the buffer.
            if (done_enter_s) begin
                rd_ptr_r <= wrapped_next_s ? wr_ptr_next_s : PTR_ZERO;
                remain_r <= fill_next_s;
            end else if ((state_r == ST_DONE) && i_read && !btn_rise_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                remain_r <= remain_r - FILL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl (ADDR_W=4) against a capture-level model.
module tb_la_capture_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] i_data, i_trig_val, i_trig_mask;
    logic          i_btn, i_read;
    logic [AW-1:0] i_post_len;
    logic          o_wr_en, o_run, o_available;
    logic [AW-1:0] o_wr_addr, o_rd_addr, o_trig_addr;
    logic [DW-1:0] o_wr_data;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] seq_q [$];

    always #5 clk = ~clk;

    la_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), ._rst(rst_n), .i_data(i_data), .i_btn(i_btn),
        .i_trig_val(i_trig_val), .i_trig_mask(i_trig_mask), .i_post_len(i_post_len),
        .i_read(i_read), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_rd_addr(o_rd_addr), .o_run(o_run), .o_available(o_available),
        .o_trig_addr(o_trig_addr)
    );

    // External sample buffer the controller addresses.
    always @(posedge clk) if (o_wr_en) mem[o_wr_addr] <= o_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic btn, input logic rd, input logic [DW-1:0] d);
        @(posedge clk); #1;
        i_btn = btn; i_read = rd; i_data = d;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run"}, o_run, 0);
        check({tag, "_avail"}, o_available, 0);
        check({tag, "_wr_en"}, o_wr_en, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_data"}, o_wr_data, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_trig_addr"}, o_trig_addr, 0);
    endtask

    // k samples that miss the trigger, one that hits, then post random samples.
    task automatic build_seq(input logic [DW-1:0] mask, input logic [DW-1:0] val,
                             input int k, input int post);
        logic [DW-1:0] x;
        seq_q.delete();
        for (int i = 0; i < k; i++) begin
            x = 8'($urandom);
            if (((x ^ val) & mask) == 8'h00) x = x ^ (mask & ~(mask - 8'h01));
            seq_q.push_back(x);
        end
        x = 8'($urandom);
        seq_q.push_back((val & mask) | (x & ~mask));
        for (int i = 0; i < post; i++) seq_q.push_back(8'($urandom));
    endtask

    // One capture of seq_q plus readout; abort_after>=0 re-arms from DONE after that many reads.
    task automatic run_capture(input logic [DW-1:0] mask, input logic [DW-1:0] val,
                               input logic [AW-1:0] post, input bit do_arm,
                               input bit btn_toggle, input bit gaps, input int abort_after);
        int k, n, cnt, start, j;
        logic rd;
        i_trig_mask = mask; i_trig_val = val; i_post_len = post;
        k = -1;
        foreach (seq_q[i]) if (k < 0 && ((seq_q[i] ^ val) & mask) == 8'h00) k = i;
        n = k + 1 + int'(post);
        if (k < 0 || n > seq_q.size()) begin
            errors++;
            $display("FAIL seq_build: observed=%0d expected<=%0d", n, seq_q.size());
            return;
        end
        if (do_arm) begin
            step(1'b1, 1'b0, 8'h00);
            check("arm_cycle_run", o_run, 0);
        end
        for (int i = 0; i < n; i++) begin
            step(btn_toggle ? i[0] : 1'b0, 1'($urandom_range(0, 1)), seq_q[i]);
            check("wr_run", o_run, 1);
            check("wr_avail", o_available, 0);
            check("wr_en", o_wr_en, 1);
            check("wr_addr", o_wr_addr, i % DEPTH);
            check("wr_data", o_wr_data, seq_q[i]);
        end
        step(1'b0, 1'b0, 8'($urandom));
        check("done_avail", o_available, 1);
        check("done_run", o_run, 0);
        check("done_wr_en", o_wr_en, 0);
        check("trig_addr", o_trig_addr, k % DEPTH);
        cnt   = (n > DEPTH) ? DEPTH : n;
        start = (n > DEPTH) ? (n % DEPTH) : 0;
        check("rd_start", o_rd_addr, start);
        j = 0;
        while (j < cnt) begin
            if (j == abort_after) begin
                step(1'b1, 1'b0, 8'h00);
                check("abort_avail", o_available, 1);
                return;
            end
            rd = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            step(1'b0, rd, 8'($urandom));
            check("rd_avail", o_available, 1);
            check("rd_addr", o_rd_addr, (start + j) % DEPTH);
            if (rd) begin
                check("rd_data", mem[o_rd_addr], seq_q[n - cnt + j]);
                j++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        check("end_avail", o_available, 0);
        check("end_run", o_run, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_btn = 1'b0; i_read = 1'b0; i_data = 8'hC3;
        i_trig_val = 8'h00; i_trig_mask = 8'hFF; i_post_len = 4'd0;
        repeat (3) @(posedge clk);
        #2 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Basic: trigger on third sample, three post samples.
        seq_q = '{8'd0, 8'd0, 8'd5, 8'd4, 8'd9, 8'd1};
        run_capture(8'hFF, 8'd5, 4'd3, 1'b1, 1'b0, 1'b0, -1);

        // Wrap: trigger at sample 20, button toggling throughout capture.
        build_seq(8'hFF, 8'd5, 20, 2);
        run_capture(8'hFF, 8'd5, 4'd2, 1'b1, 1'b1, 1'b1, -1);

        // Partial mask and zero mask.
        seq_q = '{8'h34, 8'h35, 8'h11, 8'h22};
        run_capture(8'h0F, 8'h05, 4'd2, 1'b1, 1'b0, 1'b0, -1);
        build_seq(8'h00, 8'h77, 0, 4);
        run_capture(8'h00, 8'h77, 4'd4, 1'b1, 1'b0, 1'b0, -1);

        // Zero post length, then button in DONE re-arms mid-readout.
        seq_q = '{8'd1, 8'd2, 8'd7};
        run_capture(8'hFF, 8'd7, 4'd0, 1'b1, 1'b0, 1'b0, 2);
        build_seq(8'hF0, 8'h90, 5, 3);
        run_capture(8'hF0, 8'h90, 4'd3, 1'b0, 1'b0, 1'b0, -1);

        // Reset in the middle of POST.
        build_seq(8'hFF, 8'hA5, 3, 10);
        i_trig_mask = 8'hFF; i_trig_val = 8'hA5; i_post_len = 4'd10;
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, seq_q[i]);
        check("pre_reset_run", o_run, 1);
        i_data = 8'h5A;
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h5A);
            check("post_reset_run", o_run, 0);
            check("post_reset_avail", o_available, 0);
            check("post_reset_rd_addr", o_rd_addr, 0);
        end

        // Randomised captures.
        for (int r = 0; r < 8; r++) begin
            logic [DW-1:0] m, v;
            int pl;
            m  = (r % 4 == 0) ? 8'hFF : 8'($urandom);
            v  = 8'($urandom);
            pl = $urandom_range(0, 15);
            build_seq(m, v, $urandom_range(0, 40), pl);
            run_capture(m, v, 4'(pl), 1'b1, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, sample-buffer address width (depth 2^ADDR_W); DATA_W, default 8, sample width.
REQ-002 Clock and reset SHALL be: one clock, clk; reset _rst, asynchronous, active-low.
REQ-003 Ports SHALL be:
- clk  in  1  sample clock, all logic rising-edge
- _rst  in  1  async active-low reset
- i_data  in  DATA_W  probe sample
- i_btn  in  1  arm request, level, synchronous; rising edge acts
- i_trig_val  in  DATA_W  trigger compare value
- i_trig_mask  in  DATA_W  compare-enable bits (1 = compare)
- i_post_len  in  ADDR_W  samples captured after trigger sample
- i_read  in  1  read-advance strobe, one pulse per sample
- o_wr_en  out  1  buffer write enable
- o_wr_addr  out  ADDR_W  buffer write address
- o_wr_data  out  DATA_W  buffer write data
- o_rd_addr  out  ADDR_W  buffer read address
- o_run  out  1  capture in progress (ARMED or POST)
- o_available  out  1  captured data readable (DONE)
- o_trig_addr  out  ADDR_W  address holding the trigger sample

Function
REQ-004 FSM SHALL have states IDLE, ARMED, POST, DONE.
REQ-005 IDLE: no writes; rising edge of i_btn -> ARMED next cycle, write pointer and fill count cleared to 0, wrapped flag cleared.
REQ-006 ARMED and POST: every cycle o_wr_en=1, o_wr_data=i_data, o_wr_addr=pointer; pointer increments mod 2^ADDR_W; wrapped flag set when pointer wraps 2^ADDR_W-1 -> 0; fill count saturates at 2^ADDR_W.
REQ-007 Trigger SHALL be ((i_data ^ i_trig_val) & i_trig_mask) == 0, evaluated only in ARMED on the sample being written that cycle; mask 0 triggers on first ARMED cycle.
REQ-008 On trigger: o_trig_addr latches current write address; i_post_len==0 -> DONE next cycle; else load post counter with i_post_len and -> POST.
REQ-009 POST SHALL write exactly i_post_len further samples, then -> DONE; trigger compare ignored in POST; i_post_len sampled only at trigger.
REQ-010 DONE: o_wr_en=0, o_available=1; read start = wrapped ? write pointer (oldest sample) : 0; remaining = fill count.
REQ-011 o_rd_addr SHALL be valid combinationally from registers while o_available=1; each cycle with i_read=1 advances o_rd_addr by 1 mod 2^ADDR_W and decrements remaining.
REQ-012 i_read on the last remaining sample -> IDLE next cycle, o_available=0.
REQ-013 i_read outside DONE SHALL be ignored; i_btn edges in ARMED/POST SHALL be ignored; i_btn rising edge in DONE SHALL discard readout and -> ARMED (as REQ-005).
REQ-014 i_read held high SHALL advance one sample per cycle.
REQ-015 o_run = (state==ARMED || state==POST), registered-state decode, no glitch on transitions.

Reset
REQ-016 _rst low SHALL asynchronously force IDLE; all outputs 0; pointers, counters, wrapped flag, o_trig_addr 0; i_btn edge-detector history 0.
REQ-017 Reset mid-capture or mid-readout SHALL abandon the operation; after release block waits for a new i_btn edge.

Structure
REQ-018 Package la_pkg SHALL hold the state enum and default ADDR_W/DATA_W constants.
REQ-019 Rising-edge detection of i_btn SHALL be sub-module la_edge_detect (one register, async reset).
REQ-020 Target size 120-400 RTL lines; no internal memory.

Verification
REQ-021 Basic: ADDR_W=8, mask 8'hFF, val 5, post_len 3, arm, data 0,0,5,4,9,1 -> trigger addr 2, writes at 0..5, DONE after addr 5; 6 reads return addrs 0..5 then IDLE.
REQ-022 Wrap: ADDR_W=4, val 5 at sample 20, post_len 2 -> o_trig_addr=4, reads start at addr 7, 16 reads, ends IDLE.
REQ-023 Mask: mask 8'h0F, val 8'h05, data 8'h35 -> triggers; mask 0 -> triggers first ARMED cycle.
REQ-024 Edge cases: post_len 0 -> DONE one cycle after trigger; i_read held high 3 cycles -> o_rd_addr +3; i_btn in POST ignored; i_btn in DONE -> ARMED, o_available 0.
REQ-025 Reset: _rst low mid-POST -> outputs 0 immediately (no clock edge), IDLE after release; i_read then ignored.
